move_sequencer: RTL

- Sequences one 2048 move on the 4x4 board register: accepts a decoded direction, slides and merges one line per cycle, spawns a tile, then evaluates win and game-over.
- Sits between the PS/2 key decoder (move source) and the display path (board consumer), replacing ad-hoc combinational move logic with a timed FSM.
- Cell storage is a 4-bit exponent: 0 = empty, e = tile 2^e.

---
 rtl/game2048_pkg.sv | 38 +++
 rtl/line_merge.sv | 51 +++++
 rtl/move_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/game2048_pkg.sv
// Shared types, encodings and board-index helpers for the 2048 move datapath.
// A cell holds a 4-bit exponent (0 = empty); the board is 16 cells, index = row*4+col.
package game2048_pkg;

  localparam int CELL_W = 4;

  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [1:0]        dir_t;
  typedef logic [2:0]        state_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam state_t ST_SEED0 = 3'd0;
  localparam state_t ST_SEED1 = 3'd1;
  localparam state_t ST_IDLE  = 3'd2;
  localparam state_t ST_SLIDE = 3'd3;
  localparam state_t ST_SPAWN = 3'd4;
  localparam state_t ST_CHECK = 3'd5;

  function automatic logic [3:0] board_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Element 0 of a line sits at the edge the tiles slide toward.
  function automatic logic [3:0] line_idx(input dir_t dir, input logic [1:0] line,
                                          input logic [1:0] k);
    case (dir)
      DIR_LEFT:  return board_idx(line, k);
      DIR_RIGHT: return board_idx(line, 2'd3 - k);
      DIR_UP:    return board_idx(k, line);
      default:   return board_idx(2'd3 - k, line);
    endcase
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational slide-and-merge of one 4-cell line toward element 0.
// Each cell merges at most once; the score delta saturates at the 13-bit limit.
module line_merge
  import game2048_pkg::*;
(
  input  cell_t [3:0]  line_i,
  output cell_t [3:0]  line_o,
  output logic  [12:0] score_delta_o
);

  function automatic logic [12:0] sat13(input logic [16:0] v);
    return (v > 17'h01FFF) ? 13'h1FFF : v[12:0];
  endfunction

  always_comb begin
    cell_t [3:0] c;
    cell_t       m;
    logic [16:0] acc;
    c   = line_i;
    m   = '0;
    acc = '0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 3; i++) begin
        if (c[i] == '0) begin
          c[i]   = c[i+1];
          c[i+1] = '0;
        end
      end
    end
    // Zeroing the absorbed cell stops the next pair from chaining off the result.
    for (int i = 0; i < 3; i++) begin
      if (c[i] != '0 && c[i] == c[i+1]) begin
        m      = (c[i] == 4'hF) ? 4'hF : c[i] + 4'd1;
        acc    = acc + (17'd1 << m);
        c[i]   = m;
        c[i+1] = '0;
      end
    end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 3; i++) begin
        if (c[i] == '0) begin
          c[i]   = c[i+1];
          c[i+1] = '0;
        end
      end
    end
    line_o        = c;
    score_delta_o = sat13(acc);
  end

endmodule

// File: rtl/move_sequencer.sv
// Timed 2048 move FSM: seeds the board, slides one line per cycle, spawns a tile
// from the LFSR, then evaluates win / game-over and pulses move_done.
module move_sequencer
  import game2048_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          WIN_EXP   = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_reset,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  input  logic        load_en,
  input  logic [63:0] load_board,
  output logic [63:0] board_flat,
  output logic [19:0] score,
  output logic        game_won,
  output logic        game_over,
  output logic        move_done,
  output logic        move_changed
);

  localparam cell_t WIN_CELL = cell_t'(WIN_EXP);

  state_t       state_q, state_d;
  cell_t [15:0] board_q, board_d;
  logic [19:0]  score_q, score_d;
  logic         won_q, won_d, over_q, over_d;
  logic         done_q, done_d, mchg_q, mchg_d;
  logic         changed_q, changed_d;
  dir_t         dir_q, dir_d;
  logic [1:0]   line_cnt_q, line_cnt_d;
  logic [15:0]  lfsr_q, lfsr_d;

  cell_t [3:0]  line_in, line_out;
  logic [12:0]  delta;
  cell_t [15:0] slide_board, spawn_board;
  logic [3:0]   pos;
  logic         found, any_win, any_empty, any_pair, line_diff;

  function automatic logic [19:0] sat_add(input logic [19:0] a, input logic [12:0] b);
    logic [20:0] s;
    s = {1'b0, a} + {8'b0, b};
    return s[20] ? 20'hFFFFF : s[19:0];
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) line_in[k] = board_q[line_idx(dir_q, line_cnt_q, 2'(k))];
  end

  line_merge u_merge (
    .line_i        (line_in),
    .line_o        (line_out),
    .score_delta_o (delta)
  );

  always_comb begin
    slide_board = board_q;
    for (int k = 0; k < 4; k++) slide_board[line_idx(dir_q, line_cnt_q, 2'(k))] = line_out[k];
    line_diff = (line_out != line_in);
  end

  // Spawn: first empty cell at or above lfsr[3:0], wrapping 15 -> 0.
  always_comb begin
    spawn_board = board_q;
    found       = 1'b0;
    pos         = '0;
    for (int k = 0; k < 16; k++) begin
      pos = lfsr_q[3:0] + 4'(k);
      if (!found && board_q[pos] == '0) begin
        spawn_board[pos] = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
        found            = 1'b1;
      end
    end
  end

  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board_q[board_idx(2'(r), 2'(c))] >= WIN_CELL) any_win = 1'b1;
        if (board_q[board_idx(2'(r), 2'(c))] == '0) any_empty = 1'b1;
        if (c < 3 && board_q[board_idx(2'(r), 2'(c))] == board_q[board_idx(2'(r), 2'(c + 1))])
          any_pair = 1'b1;
        if (r < 3 && board_q[board_idx(2'(r), 2'(c))] == board_q[board_idx(2'(r + 1), 2'(c))])
          any_pair = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    score_d    = score_q;
    won_d      = won_q;
    over_d     = over_q;
    done_d     = 1'b0;
    mchg_d     = mchg_q;
    changed_d  = changed_q;
    dir_d      = dir_q;
    line_cnt_d = line_cnt_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (game_reset) begin
      board_d = '0;
      score_d = '0;
      won_d   = 1'b0;
      over_d  = 1'b0;
      mchg_d  = 1'b0;
      state_d = ST_SEED0;
    end else begin
      case (state_q)
        ST_SEED0: begin
          board_d = spawn_board;
          state_d = ST_SEED1;
        end
        ST_SEED1: begin
          board_d = spawn_board;
          state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (load_en) begin
            board_d   = load_board;
            over_d    = 1'b0;
            changed_d = 1'b0;
            state_d   = ST_CHECK;
          end else if (move_valid && !over_q) begin
            dir_d      = move_dir;
            line_cnt_d = '0;
            changed_d  = 1'b0;
            state_d    = ST_SLIDE;
          end
        end
        ST_SLIDE: begin
          board_d    = slide_board;
          score_d    = sat_add(score_q, delta);
          changed_d  = changed_q | line_diff;
          line_cnt_d = line_cnt_q + 2'd1;
          if (line_cnt_q == 2'd3) state_d = (changed_q | line_diff) ? ST_SPAWN : ST_CHECK;
        end
        ST_SPAWN: begin
          board_d = spawn_board;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          won_d   = won_q | any_win;
          over_d  = !any_empty && !any_pair;
          done_d  = 1'b1;
          mchg_d  = changed_q;
          state_d = ST_IDLE;
        end
        default: state_d = ST_SEED0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SEED0;
      board_q    <= '0;
      score_q    <= '0;
      won_q      <= 1'b0;
      over_q     <= 1'b0;
      done_q     <= 1'b0;
      mchg_q     <= 1'b0;
      changed_q  <= 1'b0;
      dir_q      <= DIR_UP;
      line_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      score_q    <= score_d;
      won_q      <= won_d;
      over_q     <= over_d;
      done_q     <= done_d;
      mchg_q     <= mchg_d;
      changed_q  <= changed_d;
      dir_q      <= dir_d;
      line_cnt_q <= line_cnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign move_ready   = (state_q == ST_IDLE) && !over_q;
  assign board_flat   = board_q;
  assign score        = score_q;
  assign game_won     = won_q;
  assign game_over    = over_q;
  assign move_done    = done_q;
  assign move_changed = mchg_q;

endmodule
